// File: rtl/awmc_actuator_drive.sv
// Washing-machine actuator driver: turns the controller's stage into interlocked valve,
// pump and motor commands with break-before-make settling, agitation, spin ramp, PWM and buzzer.
module awmc_actuator_drive #(
  parameter int AGITATE_CYC = 8,
  parameter int DEAD_CYC    = 2,
  parameter int WASH_DUTY   = 6,
  parameter int SPIN_DUTY   = 15,
  parameter int RAMP_CYC    = 4,
  parameter int BUZZ_CYC    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       valve_in,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_pwm,
  output logic       buzzer,
  output logic       fault
);

  localparam logic [2:0] ST_FILL  = 3'b000;
  localparam logic [2:0] ST_WASH  = 3'b001;
  localparam logic [2:0] ST_RINSE = 3'b010;
  localparam logic [2:0] ST_DRAIN = 3'b011;
  localparam logic [2:0] ST_SPIN  = 3'b100;
  localparam logic [2:0] ST_BAD1  = 3'b101;
  localparam logic [2:0] ST_BAD2  = 3'b110;
  localparam logic [2:0] ST_IDLE  = 3'b111;

  localparam int PERIOD = 2 * (AGITATE_CYC + DEAD_CYC);
  localparam int PW = $clog2(PERIOD);
  localparam int SW = $clog2(DEAD_CYC + 1);
  localparam int RW = $clog2(RAMP_CYC + 1);
  localparam int BW = $clog2(BUZZ_CYC + 1);

  localparam logic [PW-1:0] POS_ZERO = PW'(0);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] FWD_END  = PW'(AGITATE_CYC);
  localparam logic [PW-1:0] DIR_BEG  = PW'(AGITATE_CYC + 1);
  localparam logic [PW-1:0] REV_BEG  = PW'(AGITATE_CYC + DEAD_CYC);
  localparam logic [PW-1:0] REV_END  = PW'(2 * AGITATE_CYC + DEAD_CYC);
  localparam logic [SW-1:0] SET_ZERO = SW'(0);
  localparam logic [SW-1:0] SET_ONE  = SW'(1);
  localparam logic [SW-1:0] SET_LAST = SW'(DEAD_CYC - 1);
  localparam logic [RW-1:0] RAMP_ZERO = RW'(0);
  localparam logic [RW-1:0] RAMP_ONE  = RW'(1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYC - 1);
  localparam logic [BW-1:0] BUZZ_ZERO = BW'(0);
  localparam logic [BW-1:0] BUZZ_ONE  = BW'(1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYC - 1);
  localparam logic [3:0] WASH_D = 4'(WASH_DUTY);
  localparam logic [3:0] SPIN_D = 4'(SPIN_DUTY);

  typedef enum logic [1:0] {OFF = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

  state_t        state_r;
  logic [2:0]    stage_q_r;
  logic [SW-1:0] settle_cnt_r;
  logic [PW-1:0] pos_r, pos_s;
  logic [RW-1:0] ramp_cnt_r, ramp_s;
  logic [3:0]    duty_r, duty_s, pwm_cnt_r, pwm_cnt_s;
  logic [BW-1:0] buzz_cnt_r;
  logic          done_q_r;
  logic          changed_s, illegal_s, run_entry_s, agit_en_s, agit_dir_s;
  logic          run_valve_s, run_drain_s, run_en_s, run_dir_s, run_pwm_s;
  logic [3:0]    run_duty_s;

  // Next-cycle agitation position, spin ramp and the RUN-state actuator image.
  always_comb begin
    pwm_cnt_s   = pwm_cnt_r + 4'd1;
    changed_s   = (stage != stage_q_r);
    illegal_s   = (stage == ST_BAD1) || (stage == ST_BAD2);
    run_entry_s = (state_r == SETTLE) && (settle_cnt_r == SET_ZERO) && !changed_s;
    if (run_entry_s) begin
      pos_s  = POS_ZERO;
      ramp_s = RAMP_ZERO;
      duty_s = WASH_D;
    end else begin
      pos_s = (pos_r == POS_LAST) ? POS_ZERO : pos_r + POS_ONE;
      if (ramp_cnt_r == RAMP_LAST) begin
        ramp_s = RAMP_ZERO;
        duty_s = (duty_r < SPIN_D) ? duty_r + 4'd1 : duty_r;
      end else begin
        ramp_s = ramp_cnt_r + RAMP_ONE;
        duty_s = duty_r;
      end
    end
    agit_en_s  = (pos_s < FWD_END) || ((pos_s >= REV_BEG) && (pos_s < REV_END));
    // Direction flips one cycle into each gap, so motor_en is low on both sides.
    agit_dir_s = (pos_s >= DIR_BEG) && (pos_s <= REV_END);
    run_valve_s = 1'b0;
    run_drain_s = 1'b0;
    run_en_s    = 1'b0;
    run_dir_s   = 1'b0;
    run_duty_s  = 4'd0;
    case (stage)
      ST_FILL:  run_valve_s = 1'b1;
      ST_WASH: begin
        run_en_s   = agit_en_s;
        run_dir_s  = agit_dir_s;
        run_duty_s = WASH_D;
      end
      ST_RINSE: begin
        run_valve_s = 1'b1;
        run_en_s    = agit_en_s;
        run_dir_s   = agit_dir_s;
        run_duty_s  = WASH_D;
      end
      ST_DRAIN: run_drain_s = 1'b1;
      ST_SPIN: begin
        run_drain_s = 1'b1;
        run_en_s    = 1'b1;
        run_duty_s  = duty_s;
      end
      default: run_valve_s = 1'b0;
    endcase
    run_pwm_s = run_en_s && (pwm_cnt_s < run_duty_s);
  end

  // Free-running PWM counter plus agitation and ramp bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_r  <= 4'd0;
      pos_r      <= POS_ZERO;
      ramp_cnt_r <= RAMP_ZERO;
      duty_r     <= 4'd0;
    end else begin
      pwm_cnt_r  <= pwm_cnt_s;
      pos_r      <= pos_s;
      ramp_cnt_r <= ramp_s;
      duty_r     <= duty_s;
    end
  end

  // Stage-change FSM with break-before-make settling and registered actuators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= OFF;
      stage_q_r    <= ST_IDLE;
      settle_cnt_r <= SET_ZERO;
      valve_in     <= 1'b0;
      drain_pump   <= 1'b0;
      motor_en     <= 1'b0;
      motor_dir    <= 1'b0;
      motor_pwm    <= 1'b0;
    end else begin
      stage_q_r <= stage;
      if (changed_s) begin
        state_r      <= SETTLE;
        settle_cnt_r <= SET_LAST;
        valve_in     <= 1'b0;
        drain_pump   <= 1'b0;
        motor_en     <= 1'b0;
        motor_pwm    <= 1'b0;
      end else begin
        case (state_r)
          SETTLE: begin
            // Direction is parked at forward while the motor is guaranteed off.
            motor_dir <= 1'b0;
            if (settle_cnt_r != SET_ZERO) begin
              settle_cnt_r <= settle_cnt_r - SET_ONE;
            end else if ((stage == ST_IDLE) || illegal_s) begin
              state_r <= OFF;
            end else begin
              state_r    <= RUN;
              valve_in   <= run_valve_s;
              drain_pump <= run_drain_s;
              motor_en   <= run_en_s;
              motor_dir  <= run_dir_s;
              motor_pwm  <= run_pwm_s;
            end
          end
          RUN: begin
            valve_in   <= run_valve_s;
            drain_pump <= run_drain_s;
            motor_en   <= run_en_s;
            motor_dir  <= run_dir_s;
            motor_pwm  <= run_pwm_s;
          end
          default: begin
            state_r    <= OFF;
            valve_in   <= 1'b0;
            drain_pump <= 1'b0;
            motor_en   <= 1'b0;
            motor_dir  <= 1'b0;
            motor_pwm  <= 1'b0;
          end
        endcase
      end
    end
  end

  // End-of-cycle buzzer pulse and sticky illegal-stage flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q_r   <= 1'b0;
      buzz_cnt_r <= BUZZ_ZERO;
      buzzer     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done_q_r <= done;
      fault    <= fault || illegal_s;
      if (done && !done_q_r) begin
        buzz_cnt_r <= BUZZ_LAST;
        buzzer     <= 1'b1;
      end else if (buzz_cnt_r != BUZZ_ZERO) begin
        buzz_cnt_r <= buzz_cnt_r - BUZZ_ONE;
        buzzer     <= 1'b1;
      end else begin
        buzzer <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_awmc_actuator_drive.sv
// Randomized and directed bench for awmc_actuator_drive; expected outputs come from a
// history-based model that re-derives each cycle from the last stage change and done rise.
module tb_awmc_actuator_drive;

  localparam int A = 8, D = 2, WD = 6, SD = 15, RC = 4, BC = 4, PER = 2 * (A + D);

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] stage;
  logic done;
  logic valve_in, drain_pump, motor_en, motor_dir, motor_pwm, buzzer, fault;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int cur = 0;
  logic [2:0] stg_h [0:4095];
  logic       dn_h  [0:4095];
  logic [6:0] ex, mk;
  wire  [6:0] obs = {valve_in, drain_pump, motor_en, motor_dir, motor_pwm, buzzer, fault};

  awmc_actuator_drive dut (
    .clk(clk), .reset_n(reset_n), .stage(stage), .done(done),
    .valve_in(valve_in), .drain_pump(drain_pump), .motor_en(motor_en),
    .motor_dir(motor_dir), .motor_pwm(motor_pwm), .buzzer(buzzer), .fault(fault)
  );

  always #5 clk = ~clk;

  // Expected outputs after edge e, from the recorded input history since reset.
  function automatic void model(input int e, output logic [6:0] exv, output logic [6:0] mkv);
    int m, k, s, p, r, duty;
    logic [2:0] prev, st;
    logic pd, v, dr, en, dir, pw, bz, fl;
    m = -1; r = -1; fl = 1'b0;
    for (int i = 0; i <= e; i++) begin
      prev = (i == 0) ? 3'b111 : stg_h[i-1];
      pd   = (i == 0) ? 1'b0 : dn_h[i-1];
      if (stg_h[i] !== prev) m = i;
      if (stg_h[i] == 3'b101 || stg_h[i] == 3'b110) fl = 1'b1;
      if (dn_h[i] && !pd) r = i;
    end
    v = 1'b0; dr = 1'b0; en = 1'b0; dir = 1'b0; duty = 0; mkv = 7'h7F;
    if (m >= 0) begin
      k = e - m;
      if (k == 0) mkv[3] = 1'b0;
      if (k >= D) begin
        s = k - D;
        st = stg_h[e];
        p = s % PER;
        case (st)
          3'd0: v = 1'b1;
          3'd1, 3'd2: begin
            v = (st == 3'd2);
            en = (p < A) || (p >= A + D && p < 2 * A + D);
            dir = (p >= A + 1) && (p <= 2 * A + D);
            duty = WD;
          end
          3'd3: dr = 1'b1;
          3'd4: begin
            dr = 1'b1; en = 1'b1;
            duty = WD + s / RC;
            if (duty > SD) duty = SD;
          end
          default: v = 1'b0;
        endcase
      end
    end
    pw = en && (((e + 1) % 16) < duty);
    bz = (r >= 0) && (e - r < BC);
    exv = {v, dr, en, dir, pw, bz, fl};
  endfunction

  task automatic tick();
    @(posedge clk);
    stg_h[n] = stage;
    dn_h[n]  = done;
    cur = n;
    n++;
    #1;
  endtask

  task automatic do_reset(input logic [2:0] st);
    reset_n = 1'b0; stage = 3'b111; done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    stage = st; reset_n = 1'b1; n = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stage = 3'b111; done = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_state got=%b want=%b", obs, 7'b0); end
  endtask

  task automatic test_fill_startup();
    do_reset(3'b000);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (valve_in !== (cur >= 2)) begin errors++; $display("FAIL fill_valve e=%0d got=%b want=%b", cur, valve_in, (cur >= 2)); end
      checks++;
      if (drain_pump !== 1'b0) begin errors++; $display("FAIL fill_drain e=%0d got=%b want=0", cur, drain_pump); end
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL fill e=%0d got=%b want=%b", cur, obs, ex); end
    end
  endtask

  task automatic test_wash();
    stage = 3'b001;
    for (int i = 0; i < 45; i++) begin
      tick();
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL wash e=%0d got=%b want=%b", cur, obs, ex); end
    end
  endtask

  task automatic test_spin();
    int hi;
    stage = 3'b100; hi = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (i >= 46) hi += motor_pwm;
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL spin e=%0d got=%b want=%b", cur, obs, ex); end
    end
    checks++;
    if (hi !== 15) begin errors++; $display("FAIL spin_sat_duty got=%0d want=15", hi); end
  endtask

  task automatic test_pause();
    stage = 3'b001;
    for (int i = 0; i < 56; i++) begin
      if (i == 25) stage = 3'b111;
      if (i == 30) stage = 3'b001;
      tick();
      if (i == 25) begin
        checks++;
        if (motor_en !== 1'b0) begin errors++; $display("FAIL pause_off got=%b want=0", motor_en); end
      end
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL pause e=%0d got=%b want=%b", cur, obs, ex); end
    end
  endtask

  task automatic test_buzzer();
    int hi;
    hi = 0; done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) done = 1'b0;
      tick();
      hi += buzzer;
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL buzz_held e=%0d got=%b want=%b", cur, obs, ex); end
    end
    checks++;
    if (hi !== 4) begin errors++; $display("FAIL buzz_len got=%0d want=4", hi); end
    hi = 0; done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) done = 1'b0;
      if (i == 2) done = 1'b1;
      tick();
      hi += buzzer;
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL buzz_retrig e=%0d got=%b want=%b", cur, obs, ex); end
    end
    checks++;
    if (hi !== 6) begin errors++; $display("FAIL buzz_retrig_len got=%0d want=6", hi); end
    done = 1'b0;
  endtask

  task automatic test_illegal();
    stage = 3'b101;
    tick();
    checks++;
    if ({valve_in, drain_pump, motor_en, fault} !== 4'b0001) begin
      errors++; $display("FAIL illegal_off got=%b want=0001", {valve_in, drain_pump, motor_en, fault});
    end
    stage = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL illegal e=%0d got=%b want=%b", cur, obs, ex); end
    end
    checks++;
    if ({valve_in, fault} !== 2'b11) begin errors++; $display("FAIL illegal_fill got=%b want=11", {valve_in, fault}); end
  endtask

  task automatic test_async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL async_reset got=%b want=%b", obs, 7'b0); end
  endtask

  task automatic test_random();
    int hold;
    logic pen, pdir;
    do_reset(3'($urandom_range(0, 4)));
    pen = 1'b0; pdir = 1'b0; hold = $urandom_range(1, 30);
    for (int i = 0; i < 500; i++) begin
      tick();
      model(cur, ex, mk); checks++;
      if ((obs & mk) !== (ex & mk)) begin errors++; $display("FAIL random e=%0d got=%b want=%b", cur, obs, ex); end
      checks++;
      if (motor_dir !== pdir && (motor_en || pen)) begin
        errors++; $display("FAIL dir_interlock e=%0d dir=%b en=%b prev_en=%b", cur, motor_dir, motor_en, pen);
      end
      checks++;
      if (valve_in && drain_pump) begin errors++; $display("FAIL valve_drain_excl e=%0d got=11 want=not both", cur); end
      pen = motor_en; pdir = motor_dir;
      hold--;
      if (hold == 0) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) stage = 3'b101;
        else if (r == 1) stage = 3'b110;
        else if (r < 5) stage = 3'b111;
        else stage = 3'(r % 5);
        hold = $urandom_range(1, 30);
      end
      if ($urandom_range(0, 5) == 0) done = ~done;
    end
  endtask

  initial begin
    test_reset();
    test_fill_startup();
    test_wash();
    test_spin();
    test_pause();
    test_buzzer();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
